video_timing_sink: RTL and testbench

- Downstream consumer of the 4-pixels-per-beat video generator stream.
- Produces raster timing (de/hsync/vsync) in 4-pixel groups and pulses start_frame once per frame to the generator.
- Buffers incoming beats in a 2-entry FIFO and drives 4 parallel 24-bit pixels per clock toward the TMDS encoders.
- Substitutes a fixed colour and flags underflow when data is late.

---
 rtl/video_pkg.sv | 39 +++
 rtl/video_beat_fifo.sv | 79 +++++++
 rtl/video_timing_sink.sv | 191 +++++++++++++++++++
 tb/tb_video_timing_sink.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video types and timing constants for the 4-pixels-per-beat stream.
// Holds the pixel and pixel-group types, the beat width and the standard
// 1080p / 720p raster timing sets, plus a helper that converts a pixel count
// into a count of 4-pixel groups.
package video_pkg;

    localparam int PIXELS_PER_BEAT = 4;
    localparam int PIXEL_W         = 24;
    localparam int GROUP_W         = PIXELS_PER_BEAT * PIXEL_W;

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef pixel_t [PIXELS_PER_BEAT-1:0] group_t;

    // 1920x1080 @ 60 Hz (148.5 MHz pixel clock)
    localparam int T1080_H_ACTIVE = 1920;
    localparam int T1080_H_FRONT  = 88;
    localparam int T1080_H_SYNC   = 44;
    localparam int T1080_H_BACK   = 148;
    localparam int T1080_V_ACTIVE = 1080;
    localparam int T1080_V_FRONT  = 4;
    localparam int T1080_V_SYNC   = 5;
    localparam int T1080_V_BACK   = 36;

    // 1280x720 @ 60 Hz (74.25 MHz pixel clock)
    localparam int T720_H_ACTIVE = 1280;
    localparam int T720_H_FRONT  = 110;
    localparam int T720_H_SYNC   = 40;
    localparam int T720_H_BACK   = 220;
    localparam int T720_V_ACTIVE = 720;
    localparam int T720_V_FRONT  = 5;
    localparam int T720_V_SYNC   = 5;
    localparam int T720_V_BACK   = 20;

    // Number of 4-pixel groups covering a pixel span (spans are multiples of 4).
    function automatic logic [15:0] groups_of(input int pixels);
        return 16'(pixels / PIXELS_PER_BEAT);
    endfunction

endpackage

// File: rtl/video_beat_fifo.sv
// Two-entry ready/valid FIFO for 4-pixel beats with a synchronous flush.
// ready is derived from the registered occupancy only, so there is no
// combinational path from push_valid to push_ready. A flush empties the FIFO
// and discards any push offered in the same cycle.
module video_beat_fifo
    import video_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               push_valid,
    output logic               push_ready,
    input  logic [GROUP_W-1:0] push_data,
    input  logic               pop,
    output logic               empty,
    output logic [GROUP_W-1:0] pop_data
);

    logic [GROUP_W-1:0] mem_reg [2];
    logic               wr_ptr_reg;
    logic               wr_ptr_next;
    logic               rd_ptr_reg;
    logic               rd_ptr_next;
    logic [1:0]         count_reg;
    logic [1:0]         count_next;
    logic               do_push;
    logic               do_pop;

    assign push_ready = ~reset & (count_reg != 2'd2);
    assign empty      = (count_reg == 2'd0);
    assign do_push    = push_valid & push_ready & ~flush;
    assign do_pop     = pop & ~empty & ~flush;
    assign pop_data   = mem_reg[rd_ptr_reg];

    // Pointer and occupancy update; flush wins over any push or pop.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = 1'b0;
            rd_ptr_next = 1'b0;
            count_next  = 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_next = ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_next = ~rd_ptr_reg;
            end
            case ({do_push, do_pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Beat storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/video_timing_sink.sv
// Raster timing sink for the 4-pixels-per-beat video generator stream.
// Counts the raster in 4-pixel groups, decodes de/hsync/vsync, requests each
// frame from the generator with start_frame, buffers beats in a 2-entry FIFO
// and emits one group of 4 pixels per clock. Late data is replaced by
// FILL_RGB and latched in the sticky underflow flag.
// Optional: define VIDEO_SINK_UNDERFLOW_COUNT_EN to add underflow_count, a
// saturating count of underflowed active groups.
module video_timing_sink
    import video_pkg::*;
#(
    parameter int          H_ACTIVE  = T1080_H_ACTIVE,
    parameter int          H_FRONT   = T1080_H_FRONT,
    parameter int          H_SYNC    = T1080_H_SYNC,
    parameter int          H_BACK    = T1080_H_BACK,
    parameter int          V_ACTIVE  = T1080_V_ACTIVE,
    parameter int          V_FRONT   = T1080_V_FRONT,
    parameter int          V_SYNC    = T1080_V_SYNC,
    parameter int          V_BACK    = T1080_V_BACK,
    parameter logic        HSYNC_POL = 1'b1,
    parameter logic        VSYNC_POL = 1'b1,
    parameter logic [23:0] FILL_RGB  = 24'h000000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] video_width,
    output logic [15:0] video_height,
    output logic        start_frame,
    output logic        ready,
    input  logic        valid,
    input  logic [63:0] bits_0,
    input  logic [63:0] bits_1,
    input  logic [63:0] bits_2,
    input  logic [63:0] bits_3,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [23:0] pixel_0,
    output logic [23:0] pixel_1,
    output logic [23:0] pixel_2,
    output logic [23:0] pixel_3,
    output logic        underflow
`ifdef VIDEO_SINK_UNDERFLOW_COUNT_EN
    ,
    output logic [15:0] underflow_count
`endif
);

    // Raster geometry in group (horizontal) and line (vertical) units.
    localparam logic [15:0] HG_TOTAL  = groups_of(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [15:0] HG_ACTIVE = groups_of(H_ACTIVE);
    localparam logic [15:0] HS_START  = groups_of(H_ACTIVE + H_FRONT);
    localparam logic [15:0] HS_END    = groups_of(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [15:0] V_TOTAL   = 16'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [15:0] V_ACT     = 16'(V_ACTIVE);
    localparam logic [15:0] VS_START  = 16'(V_ACTIVE + V_FRONT);
    localparam logic [15:0] VS_END    = 16'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [15:0]        hg_reg;
    logic [15:0]        hg_next;
    logic [15:0]        v_reg;
    logic [15:0]        v_next;
    logic               active;

    logic               de_reg;
    logic               de_next;
    logic               hsync_reg;
    logic               hsync_next;
    logic               vsync_reg;
    logic               vsync_next;
    group_t             group_reg;
    group_t             group_next;
    logic               underflow_reg;
    logic               underflow_next;

    logic               fifo_empty;
    logic [GROUP_W-1:0] fifo_data;
    logic [GROUP_W-1:0] push_data;
    logic               unused_bits;

    assign video_width  = 16'(H_ACTIVE);
    assign video_height = 16'(V_ACTIVE);

    // Only the low 24 bits of each 64-bit lane carry a pixel; pixel x sits in lane 0.
    assign push_data   = {bits_3[23:0], bits_2[23:0], bits_1[23:0], bits_0[23:0]};
    assign unused_bits = ^{bits_0[63:24], bits_1[63:24], bits_2[63:24], bits_3[63:24]};

    assign active      = (hg_reg < HG_ACTIVE) && (v_reg < V_ACT);
    // The frame request doubles as the FIFO flush so the stream realigns to the raster.
    assign start_frame = ~reset && (hg_reg == 16'd0) && (v_reg == VS_START);

    video_beat_fifo u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (start_frame),
        .push_valid (valid),
        .push_ready (ready),
        .push_data  (push_data),
        .pop        (active),
        .empty      (fifo_empty),
        .pop_data   (fifo_data)
    );

    // Raster counters: hg wraps at the end of a line, v advances on that wrap.
    always_comb begin
        hg_next = hg_reg + 16'd1;
        v_next  = v_reg;
        if (hg_reg == HG_TOTAL - 16'd1) begin
            hg_next = 16'd0;
            v_next  = (v_reg == V_TOTAL - 16'd1) ? 16'd0 : v_reg + 16'd1;
        end
    end

    // Counter state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            hg_reg <= 16'd0;
            v_reg  <= 16'd0;
        end else begin
            hg_reg <= hg_next;
            v_reg  <= v_next;
        end
    end

    // Decode timing and select the pixel source for the current group.
    always_comb begin
        de_next        = active;
        hsync_next     = ((hg_reg >= HS_START) && (hg_reg < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_next     = ((v_reg >= VS_START) && (v_reg < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        group_next     = '0;
        underflow_next = underflow_reg;
        if (active) begin
            if (fifo_empty) begin
                group_next     = {PIXELS_PER_BEAT{FILL_RGB}};
                underflow_next = 1'b1;
            end else begin
                group_next = fifo_data;
            end
        end
    end

    // Output register: all video outputs share one stage so they stay aligned.
    always_ff @(posedge clock) begin
        if (reset) begin
            de_reg        <= 1'b0;
            hsync_reg     <= ~HSYNC_POL;
            vsync_reg     <= ~VSYNC_POL;
            group_reg     <= '0;
            underflow_reg <= 1'b0;
        end else begin
            de_reg        <= de_next;
            hsync_reg     <= hsync_next;
            vsync_reg     <= vsync_next;
            group_reg     <= group_next;
            underflow_reg <= underflow_next;
        end
    end

    assign de        = de_reg;
    assign hsync     = hsync_reg;
    assign vsync     = vsync_reg;
    assign pixel_0   = group_reg[0];
    assign pixel_1   = group_reg[1];
    assign pixel_2   = group_reg[2];
    assign pixel_3   = group_reg[3];
    assign underflow = underflow_reg;

`ifdef VIDEO_SINK_UNDERFLOW_COUNT_EN
    logic [15:0] ucount_reg;
    logic [15:0] ucount_next;

    // Count underflowed active groups, holding at full scale.
    always_comb begin
        ucount_next = ucount_reg;
        if (active && fifo_empty && (ucount_reg != 16'hFFFF)) begin
            ucount_next = ucount_reg + 16'd1;
        end
    end

    // Underflow counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            ucount_reg <= 16'd0;
        end else begin
            ucount_reg <= ucount_next;
        end
    end

    assign underflow_count = ucount_reg;
`endif

endmodule

// File: tb/tb_video_timing_sink.sv
// Directed bench for video_timing_sink using the small test raster:
// 8 groups per line, 8 lines per frame (64 cycles), 4x4 active groups,
// hsync at hg 5, vsync and start_frame on line 5.
module tb_video_timing_sink;

    localparam logic [23:0] FILL     = 24'hABCDEF;
    localparam logic [95:0] FILL_GRP = {4{FILL}};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [63:0] bits_0 = '0;
    logic [63:0] bits_1 = '0;
    logic [63:0] bits_2 = '0;
    logic [63:0] bits_3 = '0;
    logic [15:0] video_width;
    logic [15:0] video_height;
    logic        start_frame;
    logic        ready;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [23:0] pixel_0;
    logic [23:0] pixel_1;
    logic [23:0] pixel_2;
    logic [23:0] pixel_3;
    logic        underflow;
`ifdef VIDEO_SINK_UNDERFLOW_COUNT_EN
    logic [15:0] underflow_count;
`endif

    int checks = 0;
    int errors = 0;

    video_timing_sink #(
        .H_ACTIVE  (16),
        .H_FRONT   (4),
        .H_SYNC    (4),
        .H_BACK    (8),
        .V_ACTIVE  (4),
        .V_FRONT   (1),
        .V_SYNC    (1),
        .V_BACK    (2),
        .HSYNC_POL (1'b1),
        .VSYNC_POL (1'b1),
        .FILL_RGB  (FILL)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .video_width  (video_width),
        .video_height (video_height),
        .start_frame  (start_frame),
        .ready        (ready),
        .valid        (valid),
        .bits_0       (bits_0),
        .bits_1       (bits_1),
        .bits_2       (bits_2),
        .bits_3       (bits_3),
        .de           (de),
        .hsync        (hsync),
        .vsync        (vsync),
        .pixel_0      (pixel_0),
        .pixel_1      (pixel_1),
        .pixel_2      (pixel_2),
        .pixel_3      (pixel_3),
        .underflow    (underflow)
`ifdef VIDEO_SINK_UNDERFLOW_COUNT_EN
        ,
        .underflow_count (underflow_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Raster position helpers for cycle p counted from reset release.
    function automatic bit act_at(input int p);
        return ((p % 8) < 4) && (((p / 8) % 8) < 4);
    endfunction

    function automatic bit sf_at(input int p);
        return ((p % 8) == 0) && (((p / 8) % 8) == 5);
    endfunction

    // Index of the active group at offset q from the start of a frame.
    function automatic int grp_idx(input int q);
        return (q / 8) * 4 + (q % 8);
    endfunction

    // Source beat n: pixel j = 0x100000 + 4n + j.
    function automatic logic [95:0] beat(input int n);
        logic [95:0] r;
        for (int j = 0; j < 4; j++) begin
            r[24*j +: 24] = 24'h100000 + 24'(n * 4 + j);
        end
        return r;
    endfunction

    function automatic logic [95:0] pix_obs();
        return {pixel_3, pixel_2, pixel_1, pixel_0};
    endfunction

    // Registered outputs at cycle c reflect the raster state of cycle c-1.
    task automatic check_cycle(input int c, input logic [95:0] exp_pix);
        int p;
        p = c - 1;
        chk($sformatf("start_frame@%0d", c), 96'(start_frame), 96'(sf_at(c)));
        chk($sformatf("de@%0d", c), 96'(de), 96'(act_at(p)));
        chk($sformatf("hsync@%0d", c), 96'(hsync), 96'((p % 8) == 5));
        chk($sformatf("vsync@%0d", c), 96'(vsync), 96'(((p / 8) % 8) == 5));
        chk($sformatf("pixels@%0d", c), pix_obs(), exp_pix);
        chk($sformatf("underflow@%0d", c), 96'(underflow), 96'(1));
        $display("cycle %0d: sf=%0b ready=%0b de=%0b hs=%0b vs=%0b pix=%h uf=%0b",
                 c, start_frame, ready, de, hsync, vsync, pix_obs(), underflow);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_de"}, 96'(de), 96'(0));
        chk({tag, "_hsync"}, 96'(hsync), 96'(0));
        chk({tag, "_vsync"}, 96'(vsync), 96'(0));
        chk({tag, "_pixels"}, pix_obs(), 96'(0));
        chk({tag, "_underflow"}, 96'(underflow), 96'(0));
        chk({tag, "_start_frame"}, 96'(start_frame), 96'(0));
        chk({tag, "_ready"}, 96'(ready), 96'(0));
`ifdef VIDEO_SINK_UNDERFLOW_COUNT_EN
        chk({tag, "_ucount"}, 96'(underflow_count), 96'(0));
`endif
        $display("%s: de=%0b hs=%0b vs=%0b pix=%h uf=%0b sf=%0b ready=%0b",
                 tag, de, hsync, vsync, pix_obs(), underflow, start_frame, ready);
    endtask

    initial begin
        int          n;
        bit          hs;
        logic [95:0] b;
        logic [95:0] exp_pix;

        // Reset state
        reset = 1'b1;
        valid = 1'b0;
        repeat (3) step();
        check_reset_state("reset");
        chk("video_width", 96'(video_width), 96'(16));
        chk("video_height", 96'(video_height), 96'(4));

        // Cycle 0 is the raster state (hg=0, v=0) right after release.
        reset = 1'b0;
        n     = 0;
        for (int c = 0; c <= 201; c++) begin
            if (c == 0) begin
                chk("start_frame@0", 96'(start_frame), 96'(0));
            end else begin
                if (!act_at(c - 1)) begin
                    exp_pix = '0;
                end else if (c - 1 >= 192) begin
                    exp_pix = beat(20 + grp_idx(c - 1 - 192));
                end else if (c - 1 >= 128) begin
                    exp_pix = beat(2 + grp_idx(c - 1 - 128));
                end else begin
                    exp_pix = FILL_GRP;
                end
                check_cycle(c, exp_pix);
            end

            if (c == 105) chk("ready_after_flush", 96'(ready), 96'(1));
            if (c == 110) chk("ready_full_stall", 96'(ready), 96'(0));
            if (c == 129) chk("ready_after_pop", 96'(ready), 96'(1));
`ifdef VIDEO_SINK_UNDERFLOW_COUNT_EN
            if (c == 100) chk("ucount_two_frames", 96'(underflow_count), 96'(32));
            if (c == 200) chk("ucount_hold", 96'(underflow_count), 96'(32));
`endif
            if (c == 201) break;

            // Source: always-valid from cycle 103, incrementing beats on handshake.
            valid  = (c >= 103);
            b      = beat(n);
            bits_0 = {40'hDEADBEEF55, b[23:0]};
            bits_1 = {40'hDEADBEEF55, b[47:24]};
            bits_2 = {40'hDEADBEEF55, b[71:48]};
            bits_3 = {40'hDEADBEEF55, b[95:72]};
            hs     = valid && ready;
            step();
            if (hs) n++;
        end

        // Reset in the middle of an active line.
        reset = 1'b1;
        valid = 1'b0;
        step();
        check_reset_state("midreset");
        reset = 1'b0;

        // Counters restart and FIFO is empty: first active group must underflow.
        for (int c = 0; c <= 41; c++) begin
            if (c == 0) begin
                chk("post_start_frame@0", 96'(start_frame), 96'(0));
            end else begin
                check_cycle(c, act_at(c - 1) ? FILL_GRP : 96'(0));
            end
`ifdef VIDEO_SINK_UNDERFLOW_COUNT_EN
            if (c == 41) chk("ucount_after_reset", 96'(underflow_count), 96'(16));
`endif
            if (c < 41) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
